// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Moore sequencer for the multi-cycle MIPS datapath (shared memory, IR,
// A/B/ALUOut/MDR registers, single ALU). It decodes the IR opcode, steps
// through each instruction's state sequence, stalls on mem_ready, and
// aborts a stalled memory access through a watchdog.
//
// Build option: define MULTICYCLE_ADDI_EN to add addi support
// (ADDI_EXEC=10, ADDI_WB=11). Without it, opcode 001000 is illegal.
//
// TIMEOUT_CYCLES = number of consecutive mem_ready=0 cycles tolerated in
// FETCH/MEM_READ/MEM_WRITE before abort (0 disables the watchdog).
// It must be < 2**WAIT_CNT_W.

module multicycle_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned WAIT_CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
`ifdef MULTICYCLE_ADDI_EN
    ,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11
`endif
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  localparam logic [WAIT_CNT_W-1:0] WAIT_MAX   = {WAIT_CNT_W{1'b1}};
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);

  // All datapath controls grouped so reset can blank them in one place.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctl_t;

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                    mem_timeout_q;
  logic                    wd_limit;
  logic                    timeout_hit;
  logic                    mem_state;
  ctl_t                    ctl;

  // The zero flag is consumed by the datapath's PCWriteCond gate, not here.
  logic unused_zero;
  assign unused_zero = zero;

  // The limit only fires while still waiting; a same-cycle mem_ready wins.
  assign wd_limit  = (TIMEOUT_CYCLES != 0) && (wait_cnt_q == WAIT_LIMIT) && !mem_ready;
  assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                     (state_q == S_MEM_WRITE);

  // State, wait counter and sticky timeout flag registers.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    if (RESET) begin
      state_q       <= S_FETCH;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_q | timeout_hit;
    end
  end

  // Next-state and Moore outputs; a watchdog abort suppresses all commits.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    ctl         = '0;
    state_d     = state_q;
    timeout_hit = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        if (mem_ready) begin
          ctl.ir_write = 1'b1;
          ctl.pc_write = 1'b1;
          state_d      = S_DECODE;
        end else if (wd_limit) begin
          timeout_hit = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_DECODE: begin
        ctl.alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EXEC;
`endif
          default: begin
            ctl.illegal_op = 1'b1;
            state_d        = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (wd_limit) begin
          timeout_hit = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_MEM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_MEM_WRITE: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
        if (mem_ready) begin
          ctl.instr_done = 1'b1;
          state_d        = S_FETCH;
        end else if (wd_limit) begin
          timeout_hit = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_EXECUTE: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
        state_d       = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst    = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = 2'b01;
        ctl.instr_done    = 1'b1;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        ctl.pc_write   = 1'b1;
        ctl.pc_source  = 2'b10;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
`ifdef MULTICYCLE_ADDI_EN
      S_ADDI_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
        state_d       = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Wait counter: counts stalled memory cycles, saturates, clears otherwise.
  always_comb begin
    wait_cnt_d = '0;
    if (mem_state && !mem_ready && !timeout_hit) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q
                                            : wait_cnt_q + WAIT_CNT_W'(1);
    end
  end

  // While RESET is high the in-flight instruction is abandoned with no writes.
  ctl_t ctl_out;
  assign ctl_out = RESET ? '0 : ctl;

  assign PCWrite     = ctl_out.pc_write;
  assign PCWriteCond = ctl_out.pc_write_cond;
  assign IorD        = ctl_out.iord;
  assign MemRead     = ctl_out.mem_read;
  assign MemWrite    = ctl_out.mem_write;
  assign IRWrite     = ctl_out.ir_write;
  assign MemtoReg    = ctl_out.mem_to_reg;
  assign RegDst      = ctl_out.reg_dst;
  assign RegWrite    = ctl_out.reg_write;
  assign ALUSrcA     = ctl_out.alu_src_a;
  assign ALUSrcB     = ctl_out.alu_src_b;
  assign ALUOp       = ctl_out.alu_op;
  assign PCSource    = ctl_out.pc_source;
  assign instr_done  = ctl_out.instr_done;
  assign illegal_op  = ctl_out.illegal_op;
  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb_multicycle_control_fsm
// Directed bench for multicycle_control_fsm (TIMEOUT_CYCLES=4). Each step
// drives inputs just after a rising edge, then checks state, the packed
// control word and mem_timeout against hand-computed constants.
// The addi steps follow MULTICYCLE_ADDI_EN.

module tb_multicycle_control_fsm;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op, mem_timeout;
  logic [3:0] state;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic exp_to   = 1'b0;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(4), .WAIT_CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout), .state(state)
  );

  always #5 CLK = ~CLK;

  // Control word order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite
  // MemtoReg RegDst RegWrite ALUSrcA ALUSrcB ALUOp PCSource instr_done illegal_op
  logic [17:0] ctl_obs;
  assign ctl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                    MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                    PCSource, instr_done, illegal_op};

  //                                PCW  PCWC IorD MR   MW   IRW  M2R  RD   RW   SA   SB     OP     PS     done ill
  localparam logic [17:0] E_ZERO  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_F_WT  = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_F_RDY = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_DEC   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_ILL   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b1};
  localparam logic [17:0] E_MADDR = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MRD   = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_MW_WT = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_MW_RD = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_EXE   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_AWB   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
  localparam logic [17:0] E_BR    = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0};
  localparam logic [17:0] E_JMP   = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0};
`ifdef MULTICYCLE_ADDI_EN
  localparam logic [17:0] E_AIEX  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0};
  localparam logic [17:0] E_AIWB  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0};
`endif

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, J = 6'b000010, BAD = 6'b111111, ADDI = 6'b001000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check this cycle's outputs, advance.
  task automatic cyc(input string tag, input logic rst, input logic [5:0] op,
                     input logic rdy, input logic z, input logic [3:0] es,
                     input logic [17:0] ec);
    RESET = rst; opcode = op; mem_ready = rdy; zero = z;
    #1;
    check({tag, " state"},   32'(state),       32'(es));
    check({tag, " ctl"},     32'(ctl_obs),     32'(ec));
    check({tag, " timeout"}, 32'(mem_timeout), 32'(exp_to));
    @(posedge CLK); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    RESET = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge CLK); #1;
    cyc("reset", 1'b1, LW, 1'b1, 1'b0, 4'd0, E_ZERO);

    // Fetch stall, then lw with mem_ready high: 0,1,2,3,4,0
    cyc("fetch_wait0", 1'b0, LW, 1'b0, 1'b0, 4'd0, E_F_WT);
    cyc("fetch_wait1", 1'b0, LW, 1'b0, 1'b0, 4'd0, E_F_WT);
    cyc("lw_fetch",    1'b0, LW, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("lw_decode",   1'b0, LW, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("lw_addr",     1'b0, LW, 1'b1, 1'b0, 4'd2, E_MADDR);
    cyc("lw_read",     1'b0, LW, 1'b1, 1'b0, 4'd3, E_MRD);
    cyc("lw_wb",       1'b0, LW, 1'b1, 1'b0, 4'd4, E_MWB);

    // sw with three stall cycles in MEM_WRITE
    cyc("sw_fetch",    1'b0, SW, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("sw_decode",   1'b0, SW, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("sw_addr",     1'b0, SW, 1'b1, 1'b0, 4'd2, E_MADDR);
    cyc("sw_wait0",    1'b0, SW, 1'b0, 1'b0, 4'd5, E_MW_WT);
    cyc("sw_wait1",    1'b0, SW, 1'b0, 1'b0, 4'd5, E_MW_WT);
    cyc("sw_wait2",    1'b0, SW, 1'b0, 1'b0, 4'd5, E_MW_WT);
    cyc("sw_done",     1'b0, SW, 1'b1, 1'b0, 4'd5, E_MW_RD);

    // R-type
    cyc("rt_fetch",    1'b0, RT, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("rt_decode",   1'b0, RT, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("rt_exec",     1'b0, RT, 1'b1, 1'b0, 4'd6, E_EXE);
    cyc("rt_wb",       1'b0, RT, 1'b1, 1'b0, 4'd7, E_AWB);

    // beq taken and not taken: same controls, datapath gates on zero
    cyc("beq1_fetch",  1'b0, BEQ, 1'b1, 1'b1, 4'd0, E_F_RDY);
    cyc("beq1_decode", 1'b0, BEQ, 1'b1, 1'b1, 4'd1, E_DEC);
    cyc("beq1_branch", 1'b0, BEQ, 1'b1, 1'b1, 4'd8, E_BR);
    cyc("beq0_fetch",  1'b0, BEQ, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("beq0_decode", 1'b0, BEQ, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("beq0_branch", 1'b0, BEQ, 1'b1, 1'b0, 4'd8, E_BR);

    // jump
    cyc("j_fetch",     1'b0, J, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("j_decode",    1'b0, J, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("j_jump",      1'b0, J, 1'b1, 1'b0, 4'd9, E_JMP);

    // illegal opcode
    cyc("bad_fetch",   1'b0, BAD, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("bad_decode",  1'b0, BAD, 1'b1, 1'b0, 4'd1, E_ILL);

    // addi: legal only with the build option
    cyc("addi_fetch",  1'b0, ADDI, 1'b1, 1'b0, 4'd0, E_F_RDY);
`ifdef MULTICYCLE_ADDI_EN
    cyc("addi_decode", 1'b0, ADDI, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("addi_exec",   1'b0, ADDI, 1'b1, 1'b0, 4'd10, E_AIEX);
    cyc("addi_wb",     1'b0, ADDI, 1'b1, 1'b0, 4'd11, E_AIWB);
`else
    cyc("addi_decode", 1'b0, ADDI, 1'b1, 1'b0, 4'd1, E_ILL);
`endif

    // Watchdog: four tolerated stalls in MEM_READ, fifth aborts to FETCH
    cyc("wd_fetch",    1'b0, LW, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("wd_decode",   1'b0, LW, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("wd_addr",     1'b0, LW, 1'b1, 1'b0, 4'd2, E_MADDR);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("wd_wait%0d", i), 1'b0, LW, 1'b0, 1'b0, 4'd3, E_MRD);
    cyc("wd_limit",    1'b0, LW, 1'b0, 1'b0, 4'd3, E_MRD);
    exp_to = 1'b1;
    cyc("wd_refetch",  1'b0, J, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("wd_j_decode", 1'b0, J, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("wd_j_jump",   1'b0, J, 1'b1, 1'b0, 4'd9, E_JMP);

    // Reset in EXECUTE: outputs blanked that cycle, FETCH and flag clear after
    cyc("rx_fetch",    1'b0, RT, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("rx_decode",   1'b0, RT, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("rx_reset",    1'b1, RT, 1'b1, 1'b0, 4'd6, E_ZERO);
    exp_to = 1'b0;

    // mem_ready on the limit cycle wins: lw completes normally
    cyc("lim_fetch",   1'b0, LW, 1'b1, 1'b0, 4'd0, E_F_RDY);
    cyc("lim_decode",  1'b0, LW, 1'b1, 1'b0, 4'd1, E_DEC);
    cyc("lim_addr",    1'b0, LW, 1'b1, 1'b0, 4'd2, E_MADDR);
    for (int i = 0; i < 4; i++)
      cyc($sformatf("lim_wait%0d", i), 1'b0, LW, 1'b0, 1'b0, 4'd3, E_MRD);
    cyc("lim_ready",   1'b0, LW, 1'b1, 1'b0, 4'd3, E_MRD);
    cyc("lim_wb",      1'b0, LW, 1'b1, 1'b0, 4'd4, E_MWB);

    // Watchdog in FETCH: stays in FETCH, flag set, no IRWrite/PCWrite
    for (int i = 0; i < 4; i++)
      cyc($sformatf("fto_wait%0d", i), 1'b0, LW, 1'b0, 1'b0, 4'd0, E_F_WT);
    cyc("fto_limit",   1'b0, LW, 1'b0, 1'b0, 4'd0, E_F_WT);
    exp_to = 1'b1;
    cyc("fto_after",   1'b0, LW, 1'b0, 1'b0, 4'd0, E_F_WT);
    cyc("fto_reset",   1'b1, LW, 1'b0, 1'b0, 4'd0, E_ZERO);
    exp_to = 1'b0;
    cyc("fto_clear",   1'b0, LW, 1'b1, 1'b0, 4'd0, E_F_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style sequencer that drives a multi-cycle version of the MIPS datapath: shared instruction/data memory, IR, A/B/ALUOut/MDR registers and a single ALU.
- Replaces the single-cycle combinational Control block for the multi-cycle processor variant.
- Decodes the opcode held in IR, steps through the per-instruction state sequence and stalls on a memory ready handshake.
- Includes a memory-wait watchdog.

Parameters:
- TIMEOUT_CYCLES, 0, number of consecutive mem_ready=0 cycles tolerated in a memory state before abort; 0 disables the watchdog.
- WAIT_CNT_W, 8, width of the wait counter; TIMEOUT_CYCLES must be < 2^WAIT_CNT_W.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  synchronous active-high reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current access this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if zero=1 (datapath gates it).
- IorD  output  1  memory address source: 0=PC, 1=ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- IRWrite  output  1  IR load.
- MemtoReg  output  1  write-back source: 0=ALUOut, 1=MDR.
- RegDst  output  1  destination register: 0=rt, 1=rd.
- RegWrite  output  1  register file write.
- ALUSrcA  output  1  ALU A input: 0=PC, 1=A register.
- ALUSrcB  output  2  ALU B input: 00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- ALUOp  output  2  00=add, 01=sub, 10=funct-decoded.
- PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump address.
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  output  1  one-cycle pulse in DECODE on an unsupported opcode.
- mem_timeout  output  1  sticky watchdog flag.
- state  output  4  current state, for debug.

Behaviour:
- Reset: on any rising edge with RESET=1, state<=FETCH(0), wait counter<=0, mem_timeout<=0.
  - While RESET=1, every control output, instr_done and illegal_op are forced to 0.
  - Reset mid-instruction abandons it; no write enable is asserted in that cycle.
- State encodings and outputs (signals not listed are 0):
  - FETCH(0): MemRead, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE(1): ALUSrcA=0, ALUSrcB=11, ALUOp=00, which computes the branch target into ALUOut. Next state by opcode:
    - 100011 (lw) or 101011 (sw) -> MEM_ADDR
    - 000000 (R-type) -> EXECUTE
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - any other opcode -> FETCH with illegal_op=1
  - MEM_ADDR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ(3): MemRead, IorD=1. Waits for mem_ready, then goes to MEM_WB.
  - MEM_WB(4): RegWrite, RegDst=0, MemtoReg=1, instr_done. Next is FETCH.
  - MEM_WRITE(5): MemWrite, IorD=1. Waits for mem_ready; instr_done=mem_ready; goes to FETCH on ready.
  - EXECUTE(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next is ALU_WB.
  - ALU_WB(7): RegWrite, RegDst=1, MemtoReg=0, instr_done. Next is FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=01, instr_done. Next is FETCH.
  - JUMP(9): PCWrite, PCSource=10, instr_done. Next is FETCH.
- Latency with mem_ready held at 1: lw 5 cycles, sw 4, R-type 4, beq 3, j 3.
- MemRead/MemWrite stay high through every wait cycle. Each access is complete on the first cycle with mem_ready=1.
- Watchdog: applies only in FETCH, MEM_READ and MEM_WRITE.
  - Wait counter increments on each cycle with mem_ready=0 and clears on any state change.
  - If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES while mem_ready=0:
    - next state is FETCH;
    - mem_timeout<=1, which holds until reset;
    - no IRWrite, PCWrite, RegWrite or instr_done is produced.
  - If mem_ready=1 arrives in the same cycle the limit is reached, mem_ready wins and the access completes normally.
  - The counter saturates and does not wrap.
- A timeout in FETCH restarts the fetch at the same PC, because PC was never written.

Optional Feature:
- Macro: MULTICYCLE_ADDI_EN.
- Defined:
  - DECODE maps opcode 001000 (addi) to ADDI_EXEC(10), with ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ADDI_EXEC goes to ADDI_WB(11), with RegWrite, RegDst=0, MemtoReg=0, instr_done; then FETCH. addi latency is 4 cycles.
- Undefined: opcode 001000 is illegal (illegal_op pulse, return to FETCH), and states 10/11 do not exist.

Test Plan:
- Reset then lw, mem_ready=1 throughout -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in cycle 5; one instr_done pulse.
- sw with mem_ready low for 3 cycles in MEM_WRITE -> MemWrite high for 4 consecutive cycles; instr_done in the 4th; next state FETCH.
- beq with zero=1, then beq with zero=0 -> each takes 3 cycles; PCWriteCond=1 and PCSource=01 in BRANCH both times; PCWrite=0.
- opcode 111111 -> illegal_op pulse in DECODE; next state FETCH; no write enables asserted.
- TIMEOUT_CYCLES=4, mem_ready stuck at 0 in MEM_READ -> after 4 wait cycles state=FETCH and mem_timeout=1 until RESET. Repeat with mem_ready=1 on the limit cycle -> normal completion, mem_timeout=0.
- RESET asserted in EXECUTE -> all outputs 0 that cycle; state=FETCH next; with MULTICYCLE_ADDI_EN defined, addi completes in 4 cycles with RegDst=0.
